// File: rtl/gatorga_pkg.sv
// Shared constants and types for the player input conditioning path.
// Button bit order matches the board pin order: P1 right/left, then P2 right/left.
package gatorga_pkg;

  localparam int NUM_BTNS    = 4;
  localparam int NUM_PLAYERS = 2;

  localparam int BTN_P1_R = 0;
  localparam int BTN_P1_L = 1;
  localparam int BTN_P2_R = 2;
  localparam int BTN_P2_L = 3;

  typedef logic [NUM_BTNS-1:0]    btn_vec_t;
  typedef logic [NUM_PLAYERS-1:0] player_vec_t;

  // Galois mask for x^16 + x^14 + x^13 + x^11 in right-shift form (bits 15,13,12,10).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One right-shift Galois step: the bit shifted out feeds back into the tap positions.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic [15:0] n;
    n = {1'b0, s[15:1]};
    if (s[0]) n = n ^ LFSR_TAPS;
    return n;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: two-flop synchroniser, stable-count debounce filter and a
// one-cycle pulse on each accepted rising edge. A new level is accepted only
// after it has been seen on the synchronised input for DEBOUNCE_CYCLES cycles.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic pixel_clk,
  input  logic rst_n,
  input  logic btn_raw_i,
  output logic stable_o,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          stable_dly_q;
  logic          press_q;

  // Synchroniser: the raw pin is only ever observed through s2_q.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btn_raw_i;
      s2_q <= s1_q;
    end
  end

  // Debounce: count while the input disagrees with the accepted level; any
  // agreement restarts the count, and the count saturates by accepting.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (s2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q < CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      stable_d = s2_q;
      cnt_d    = '0;
    end
  end

  // Filter state plus a delayed copy of the accepted level for edge detection.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      press_q      <= stable_q & ~stable_dly_q;
    end
  end

  assign stable_o = stable_q;
  assign press_o  = press_q;

endmodule

// File: rtl/player_input_cond.sv
// Conditions the four raw player buttons for the paddle blocks (pixel_clk domain).
// Each button is synchronised and debounced; per player, simultaneous left and
// right cancel out, and the resulting direction is sampled once per frame on fsync.
// Optional feature macro: PLAYER_INPUT_LFSR_EN adds a free-running 16-bit LFSR
// whose low bit is captured into rand_dir on every button press (serve direction).
module player_input_cond
  import gatorga_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 250000,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic       pixel_clk,
  input  logic       rst_n,
  input  logic       fsync,
  input  logic [3:0] btn_raw,
  output logic [3:0] btn_stable,
  output logic [3:0] press_pulse,
  output logic [1:0] move_right,
  output logic [1:0] move_left,
  output logic       rand_dir
);

  btn_vec_t    stable_w, press_w;
  player_vec_t want_r, want_l;
  player_vec_t move_r_q, move_l_q;

  // One filter per button.
  for (genvar b = 0; b < NUM_BTNS; b++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .pixel_clk(pixel_clk),
      .rst_n    (rst_n),
      .btn_raw_i(btn_raw[b]),
      .stable_o (stable_w[b]),
      .press_o  (press_w[b])
    );
  end

  // Conflict resolution from registered debounced levels: both held means neither.
  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    localparam int R = (p == 0) ? BTN_P1_R : BTN_P2_R;
    localparam int L = (p == 0) ? BTN_P1_L : BTN_P2_L;
    assign want_r[p] = stable_w[R] & ~stable_w[L];
    assign want_l[p] = stable_w[L] & ~stable_w[R];
  end

  // Frame latch: directions only move on fsync cycles (every such cycle if held).
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      move_r_q <= '0;
      move_l_q <= '0;
    end else if (fsync) begin
      move_r_q <= want_r;
      move_l_q <= want_l;
    end
  end

  assign btn_stable  = stable_w;
  assign press_pulse = press_w;
  assign move_right  = move_r_q;
  assign move_left   = move_l_q;

`ifdef PLAYER_INPUT_LFSR_EN
  logic [15:0] lfsr_q;
  logic        rand_q;

  // Free-running LFSR; a press samples its low bit as the serve direction.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
      rand_q <= 1'b0;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
      if (|press_w) rand_q <= lfsr_q[0];
    end
  end

  assign rand_dir = rand_q;
`else
  // Seed is meaningless without the LFSR; fold it into a sink to keep lint quiet.
  logic seed_unused;
  assign seed_unused = ^LFSR_SEED;
  assign rand_dir    = 1'b0;
`endif

endmodule
